// File: rtl/gt_rst_pkg.sv
// Purpose : shared types and constants for the GT reset sequencer slice.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: state encoding, cycle-counter width, retry-counter width and a
// saturating increment helper for the cycle counter.
package gt_rst_pkg;

   localparam int CNT_W   = 24;
   localparam int RETRY_W = 8;

   // Encoding is visible on o_state, so values are pinned explicitly.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_GT_RST    = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_LINK_UP   = 3'd4
   } state_e;

   // Saturating increment: holds at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/gt_rst_seq_sync_2ff.sv
// Purpose : two-flop synchronizer for one asynchronous level signal.
// Latency : 2 i_clk cycles from input change to o_q.
// Backpressure: none; free-running level path.
//
// Ports: i_clk clock, i_rst async active-high reset (clears both flops),
//        i_d asynchronous input, o_q synchronized output.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = i_d;
      sync_d = meta_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/gt_rst_seq.sv
// Purpose : GT bring-up reset sequencer (lock -> GT reset pulse -> wait done -> link up).
// Latency : 2 cycles of input synchronization, then 1 cycle to registered outputs.
// Backpressure: none; status levels are sampled every cycle, no handshake.
//
// Ports: i_clk, i_rst (async, active-high); i_pll_lock, i_tx_done, i_rx_done
//        (async status levels); o_gt_rst, o_user_rst (active-high resets);
//        o_state (debug state encoding); o_retry_cnt (saturating watchdog retries).
// Build option: define RST_SEQ_WATCHDOG_EN to enable the WAIT_DONE watchdog;
//        without it WAIT_DONE waits forever and o_retry_cnt stays 0.
module gt_rst_seq
   import gt_rst_pkg::*;
#(
   parameter int P_GT_RST_CYCLE = 16,
   parameter int P_DONE_TIMEOUT = 1_000_000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_pll_lock,
   input  logic               i_tx_done,
   input  logic               i_rx_done,
   output logic               o_gt_rst,
   output logic               o_user_rst,
   output logic [2:0]         o_state,
   output logic [RETRY_W-1:0] o_retry_cnt
);

   // A zero-length GT reset is meaningless; it is stretched to one cycle.
   localparam logic [CNT_W-1:0] GT_RST_LAST =
      (P_GT_RST_CYCLE <= 1) ? '0 : CNT_W'(P_GT_RST_CYCLE - 1);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(P_DONE_TIMEOUT - 1);

   logic lock_s, tx_done_s, rx_done_s;

   sync_2ff u_sync_lock (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_pll_lock), .o_q(lock_s));
   sync_2ff u_sync_tx   (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_tx_done),  .o_q(tx_done_s));
   sync_2ff u_sync_rx   (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_rx_done),  .o_q(rx_done_s));

   state_e               state_d, state_q;
   logic [CNT_W-1:0]     cnt_d, cnt_q;
   logic [RETRY_W-1:0]   retry_d, retry_q;
   logic                 gt_rst_d, gt_rst_q;
   logic                 user_rst_d, user_rst_q;
   logic                 wd_expired;

`ifdef RST_SEQ_WATCHDOG_EN
   assign wd_expired = (cnt_q == DONE_LAST);
`else
   // Watchdog compiled out: the compare is forced false and folds away, it only
   // keeps the timeout parameter referenced so both builds share one interface.
   assign wd_expired = (cnt_q == DONE_LAST) & 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (lock_s) state_d = ST_GT_RST;
         end
         ST_GT_RST: begin
            if (!lock_s)                   state_d = ST_WAIT_LOCK;
            else if (cnt_q >= GT_RST_LAST) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (wd_expired) begin
               state_d = ST_GT_RST;
               retry_d = (&retry_q) ? retry_q : retry_q + 1'b1;
            end else if (tx_done_s && rx_done_s) begin
               state_d = ST_LINK_UP;
            end
         end
         ST_LINK_UP: begin
            if (!lock_s || !tx_done_s || !rx_done_s) state_d = ST_WAIT_LOCK;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Counter restarts on every state change, otherwise counts up and sticks at max.
      cnt_d = (state_d != state_q) ? '0 : cnt_sat_inc(cnt_q);

      // Outputs are decoded from the next state so they change on the same edge as the state.
      gt_rst_d   = (state_d == ST_IDLE) || (state_d == ST_WAIT_LOCK) || (state_d == ST_GT_RST);
      user_rst_d = (state_d != ST_LINK_UP);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         retry_q    <= '0;
         gt_rst_q   <= 1'b1;
         user_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         gt_rst_q   <= gt_rst_d;
         user_rst_q <= user_rst_d;
      end
   end

   assign o_gt_rst    = gt_rst_q;
   assign o_user_rst  = user_rst_q;
   assign o_state     = state_q;
   assign o_retry_cnt = retry_q;

endmodule
